pipeline_id: RTL and testbench
==============================

PIPELINE_ID -- requirements
Module: pipeline_id

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  asynchronous, active-low reset.
REQ-002 SHALL have ports: pc_i  in  32  PC from fetch; inst_i  in  32  instruction from fetch (32'h0 = bubble).
REQ-003 SHALL have ports: stall_i  in  5  per-stage hold vector; flush_i  in  5  per-stage flush vector; stall_o  out  1  load-use stall request.
REQ-004 SHALL have ports: rs1_addr_o/rs2_addr_o  out  5  regfile read addresses; rs1_data_i/rs2_data_i  in  32  regfile read data (same cycle).
REQ-005 SHALL have ports: ex_wreg_i  in  1, ex_wd_i  in  5, ex_wdata_i  in  32, ex_is_load_i  in  1  (EX-stage writeback forward); mem_wreg_i  in  1, mem_wd_i  in  5, mem_wdata_i  in  32  (MEM-stage forward).
REQ-006 SHALL have registered outputs: pc_o 32, opcode_o 7, funct3_o 3, funct7b5_o 1, rs1_val_o 32, rs2_val_o 32, imm_o 32, rd_o 5, wreg_o 1, op_o 2, illegal_o 1.

Function
REQ-007 SHALL decode RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP; any other nonzero opcode SHALL set illegal_o=1, wreg_o=0, op_o=OpTypeNop.
REQ-008 SHALL generate imm_o sign-extended per format: I (LOAD/OP-IMM/JALR), S, B (bit0=0), U (low 12 bits zero), J (bit0=0); R-type imm_o=0.
REQ-009 SHALL set op_o: OpTypeBranch for JAL/JALR/BRANCH, OpTypeMem for LOAD/STORE, OpTypeAlu otherwise, OpTypeNop for bubbles.
REQ-010 SHALL set wreg_o=1 only for LUI/AUIPC/JAL/JALR/LOAD/OP-IMM/OP with rd!=0.
REQ-011 SHALL drive rs1_addr_o=inst_i[19:15], rs2_addr_o=inst_i[24:20] combinationally; unused source fields SHALL not cause forwarding or stall.
REQ-012 SHALL resolve each used source: x0 -> 0; else EX match (ex_wreg_i, ex_wd_i==rs, not load) -> ex_wdata_i; else MEM match -> mem_wdata_i; else regfile data. EX SHALL take priority over MEM.
REQ-013 SHALL assert stall_o combinationally when ex_is_load_i && ex_wreg_i && ex_wd_i!=0 && ex_wd_i equals a used source.
REQ-014 On each rising edge, update rule: stall_i[2]=0 -> capture decoded values; stall_i[2]=1 && stall_i[3]=0 -> load bubble; stall_i[2]=1 && stall_i[3]=1 -> hold all outputs.
REQ-015 Bubble SHALL mean opcode_o, funct3_o, funct7b5_o, imm_o, rs*_val_o, rd_o, wreg_o, illegal_o = 0, op_o=OpTypeNop; pc_o SHALL still take pc_i.
REQ-016 flush_i[2]=1 SHALL load a bubble on the next edge, overriding REQ-014 capture and hold.
REQ-017 inst_i==32'h0 SHALL decode as bubble, illegal_o=0, stall_o=0.
REQ-018 Latency: one cycle from inst_i/pc_i to registered outputs; no internal instruction buffering.
REQ-019 stall_o and the controller's stall_i[2] response SHALL be assumed mutually consistent; pipeline_id SHALL not gate its own capture on stall_o.

Reset
REQ-020 rst=0 SHALL asynchronously clear every registered output to zero (op_o=OpTypeNop); stall_o SHALL be 0 while rst=0.
REQ-021 Deassertion mid-stream SHALL resume capture on the first rising edge with rst=1.

Structure
REQ-022 Opcode constants, OpType codes (Nop=00, Alu=01, Mem=10, Branch=11), InstWidth, MemAddrWidth and ZeroWord SHALL live in shared define.v.
REQ-023 Immediate generation SHALL be one sub-module imm_gen (inst 32 in, imm 32 out, combinational); forwarding and register stage remain in pipeline_id.

Verification
REQ-024 ADDI x5,x0,-1 (32'hFFF00293), pc 0x100 -> next edge: imm_o=32'hFFFFFFFF, rd_o=5, wreg_o=1, op_o=Alu, pc_o=0x100.
REQ-025 ADD x3,x1,x2; ex_wd_i=1, ex_wdata_i=7; mem_wd_i=2, mem_wdata_i=9; regfile 1/2 -> rs1_val_o=7, rs2_val_o=9.
REQ-026 LW in EX (ex_is_load_i=1, ex_wd_i=4) and ADD x6,x4,x0 in ID -> stall_o=1; with stall_i=5'b00111 -> bubble loaded next edge.
REQ-027 BEQ offset -8 (32'hFE000CE3) -> imm_o=32'hFFFFFFF8, op_o=Branch, wreg_o=0; JAL x0 -> wreg_o=0.
REQ-028 stall_i=5'b01111 for 3 cycles -> outputs unchanged; flush_i[2]=1 during stall -> bubble; rst=0 mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
REQ-029 Write to x0 via EX forward (ex_wd_i=0, ex_wdata_i=5), ADD using x0 -> rs1_val_o=0; opcode 7'b0001011 -> illegal_o=1.

Source files
------------

// File: rtl/pipeline_id_pkg.sv
// pipeline_id_pkg -- shared definitions for the RV32I decode stage.
//   * machine-word widths and the all-zero word (also the bubble encoding)
//   * RV32I major opcode constants
//   * OpType codes that steer the downstream EX stage
//   * id_out_t: the full set of registered decode-stage outputs
//   * id_bubble(): helper that builds a bubble for a given PC
package pipeline_id_pkg;

  localparam int          InstWidth    = 32;
  localparam int          MemAddrWidth = 32;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;

  // RV32I major opcodes (inst[6:0])
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;

  typedef enum logic [1:0] {
    OpTypeNop    = 2'b00,
    OpTypeAlu    = 2'b01,
    OpTypeMem    = 2'b10,
    OpTypeBranch = 2'b11
  } op_type_e;

  typedef struct packed {
    logic [MemAddrWidth-1:0] pc;
    logic [6:0]              opcode;
    logic [2:0]              funct3;
    logic                    funct7b5;
    logic [31:0]             rs1_val;
    logic [31:0]             rs2_val;
    logic [31:0]             imm;
    logic [4:0]              rd;
    logic                    wreg;
    op_type_e                op;
    logic                    illegal;
  } id_out_t;

  // A bubble is all-zero except that the PC keeps flowing down the pipe.
  function automatic id_out_t id_bubble(input logic [MemAddrWidth-1:0] pc);
    id_out_t b;
    b    = '0;
    b.op = OpTypeNop;
    b.pc = pc;
    return b;
  endfunction

endpackage

// File: rtl/pipeline_id_imm_gen.sv
// imm_gen -- combinational RV32I immediate generator.
//   inst_i : 32-bit instruction word
//   imm_o  : sign-extended immediate for the instruction's format
//            (I, S, B, U, J); zero for R-type and unknown opcodes.
module imm_gen
  import pipeline_id_pkg::*;
(
  input  logic [InstWidth-1:0] inst_i,
  output logic [31:0]          imm_o
);

  always_comb begin
    imm_o = ZeroWord;
    case (inst_i[6:0])
      OpcLoad, OpcOpImm, OpcJalr:
        imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
      OpcStore:
        imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      OpcBranch:
        imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                 inst_i[11:8], 1'b0};
      OpcLui, OpcAuipc:
        imm_o = {inst_i[31:12], 12'h000};
      OpcJal:
        imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                 inst_i[30:21], 1'b0};
      default:
        imm_o = ZeroWord;
    endcase
  end

endmodule

// File: rtl/pipeline_id.sv
// pipeline_id -- RV32I instruction-decode stage with operand forwarding.
//   clk, rst                 : clock (rising edge) and async active-low reset
//   pc_i, inst_i             : PC / instruction from fetch (inst 0 = bubble)
//   stall_i, flush_i         : per-stage hold / flush vectors (bit 2 = ID,
//                              bit 3 = EX)
//   stall_o                  : load-use hazard request (combinational)
//   rs1/rs2_addr_o, _data_i  : regfile read port, data returned same cycle
//   ex_*, mem_*              : writeback forwarding from the EX and MEM stages
//   pc_o .. illegal_o        : registered decode results, one cycle latency
module pipeline_id
  import pipeline_id_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MemAddrWidth-1:0] pc_i,
  input  logic [InstWidth-1:0]    inst_i,
  input  logic [4:0]              stall_i,
  input  logic [4:0]              flush_i,
  output logic                    stall_o,
  output logic [4:0]              rs1_addr_o,
  output logic [4:0]              rs2_addr_o,
  input  logic [31:0]             rs1_data_i,
  input  logic [31:0]             rs2_data_i,
  input  logic                    ex_wreg_i,
  input  logic [4:0]              ex_wd_i,
  input  logic [31:0]             ex_wdata_i,
  input  logic                    ex_is_load_i,
  input  logic                    mem_wreg_i,
  input  logic [4:0]              mem_wd_i,
  input  logic [31:0]             mem_wdata_i,
  output logic [MemAddrWidth-1:0] pc_o,
  output logic [6:0]              opcode_o,
  output logic [2:0]              funct3_o,
  output logic                    funct7b5_o,
  output logic [31:0]             rs1_val_o,
  output logic [31:0]             rs2_val_o,
  output logic [31:0]             imm_o,
  output logic [4:0]              rd_o,
  output logic                    wreg_o,
  output logic [1:0]              op_o,
  output logic                    illegal_o
);

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic        is_bubble;
  logic [31:0] imm;

  logic        known;
  logic        writes_rd;
  op_type_e    op_type;
  logic [1:0]  rs_used;

  logic [1:0][4:0]  rs_addr;
  logic [1:0][31:0] rf_data;
  logic [1:0][31:0] rs_val;
  logic [1:0]       hazard;

  id_out_t dec;
  id_out_t out_d;
  id_out_t out_q;

  // Only the ID/EX bits of the control vectors matter here.
  logic unused_ctrl;
  assign unused_ctrl = ^{stall_i[4], stall_i[1:0], flush_i[4:3], flush_i[1:0]};

  assign opcode     = inst_i[6:0];
  assign rd         = inst_i[11:7];
  assign is_bubble  = (inst_i == ZeroWord);
  assign rs1_addr_o = inst_i[19:15];
  assign rs2_addr_o = inst_i[24:20];

  imm_gen u_imm_gen (
    .inst_i (inst_i),
    .imm_o  (imm)
  );

  // Opcode classification: which sources are read, whether rd is written,
  // and which execution unit class the instruction goes to.
  always_comb begin
    known     = 1'b1;
    writes_rd = 1'b0;
    op_type   = OpTypeNop;
    rs_used   = 2'b00;
    case (opcode)
      OpcLui, OpcAuipc: begin writes_rd = 1'b1; op_type = OpTypeAlu; end
      OpcJal:           begin writes_rd = 1'b1; op_type = OpTypeBranch; end
      OpcJalr:   begin writes_rd = 1'b1; op_type = OpTypeBranch; rs_used = 2'b01; end
      OpcBranch: begin                   op_type = OpTypeBranch; rs_used = 2'b11; end
      OpcLoad:   begin writes_rd = 1'b1; op_type = OpTypeMem;    rs_used = 2'b01; end
      OpcStore:  begin                   op_type = OpTypeMem;    rs_used = 2'b11; end
      OpcOpImm:  begin writes_rd = 1'b1; op_type = OpTypeAlu;    rs_used = 2'b01; end
      OpcOp:     begin writes_rd = 1'b1; op_type = OpTypeAlu;    rs_used = 2'b11; end
      default:   known = 1'b0;
    endcase
    // A bubble reads nothing, so it can never forward or stall.
    if (is_bubble) begin
      rs_used = 2'b00;
    end
  end

  assign rs_addr = {rs2_addr_o, rs1_addr_o};
  assign rf_data = {rs2_data_i, rs1_data_i};

  // Per-source operand resolution. A load in EX has no data yet, so it is
  // skipped here; the hazard term raises stall_o and the controller will
  // replace this instruction with a bubble anyway.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_src
    logic ex_hit;
    logic mem_hit;
    assign ex_hit  = ex_wreg_i && !ex_is_load_i && (ex_wd_i == rs_addr[gi]);
    assign mem_hit = mem_wreg_i && (mem_wd_i == rs_addr[gi]);
    assign rs_val[gi] = (!rs_used[gi] || rs_addr[gi] == 5'd0) ? ZeroWord :
                        ex_hit  ? ex_wdata_i  :
                        mem_hit ? mem_wdata_i : rf_data[gi];
    assign hazard[gi] = rs_used[gi] && ex_is_load_i && ex_wreg_i &&
                        (ex_wd_i != 5'd0) && (ex_wd_i == rs_addr[gi]);
  end

  assign stall_o = rst && (|hazard);

  always_comb begin
    if (is_bubble) begin
      dec = id_bubble(pc_i);
    end else begin
      dec          = '0;
      dec.pc       = pc_i;
      dec.opcode   = opcode;
      dec.funct3   = inst_i[14:12];
      dec.funct7b5 = inst_i[30];
      dec.rs1_val  = rs_val[0];
      dec.rs2_val  = rs_val[1];
      dec.imm      = imm;
      dec.rd       = rd;
      dec.wreg     = known && writes_rd && (rd != 5'd0);
      dec.op       = known ? op_type : OpTypeNop;
      dec.illegal  = !known;
    end
  end

  // Flush beats everything; otherwise capture, bubble (ID held but EX moving)
  // or hold (both held).
  always_comb begin
    out_d = out_q;
    if (flush_i[2]) begin
      out_d = id_bubble(pc_i);
    end else if (!stall_i[2]) begin
      out_d = dec;
    end else if (!stall_i[3]) begin
      out_d = id_bubble(pc_i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign pc_o       = out_q.pc;
  assign opcode_o   = out_q.opcode;
  assign funct3_o   = out_q.funct3;
  assign funct7b5_o = out_q.funct7b5;
  assign rs1_val_o  = out_q.rs1_val;
  assign rs2_val_o  = out_q.rs2_val;
  assign imm_o      = out_q.imm;
  assign rd_o       = out_q.rd;
  assign wreg_o     = out_q.wreg;
  assign op_o       = out_q.op;
  assign illegal_o  = out_q.illegal;

endmodule

// File: tb/tb_pipeline_id.sv
// tb_pipeline_id -- directed bench for pipeline_id with hand-computed
// expectations, one check line per failing comparison.
module tb_pipeline_id;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic [4:0]  stall_i;
  logic [4:0]  flush_i;
  logic        stall_o;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        ex_wreg_i;
  logic [4:0]  ex_wd_i;
  logic [31:0] ex_wdata_i;
  logic        ex_is_load_i;
  logic        mem_wreg_i;
  logic [4:0]  mem_wd_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] pc_o;
  logic [6:0]  opcode_o;
  logic [2:0]  funct3_o;
  logic        funct7b5_o;
  logic [31:0] rs1_val_o;
  logic [31:0] rs2_val_o;
  logic [31:0] imm_o;
  logic [4:0]  rd_o;
  logic        wreg_o;
  logic [1:0]  op_o;
  logic        illegal_o;

  int total = 0;
  int bad   = 0;

  pipeline_id dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .inst_i       (inst_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .stall_o      (stall_o),
    .rs1_addr_o   (rs1_addr_o),
    .rs2_addr_o   (rs2_addr_o),
    .rs1_data_i   (rs1_data_i),
    .rs2_data_i   (rs2_data_i),
    .ex_wreg_i    (ex_wreg_i),
    .ex_wd_i      (ex_wd_i),
    .ex_wdata_i   (ex_wdata_i),
    .ex_is_load_i (ex_is_load_i),
    .mem_wreg_i   (mem_wreg_i),
    .mem_wd_i     (mem_wd_i),
    .mem_wdata_i  (mem_wdata_i),
    .pc_o         (pc_o),
    .opcode_o     (opcode_o),
    .funct3_o     (funct3_o),
    .funct7b5_o   (funct7b5_o),
    .rs1_val_o    (rs1_val_o),
    .rs2_val_o    (rs2_val_o),
    .imm_o        (imm_o),
    .rd_o         (rd_o),
    .wreg_o       (wreg_o),
    .op_o         (op_o),
    .illegal_o    (illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Advance one edge and land 1 time unit after it to sample.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    ex_wreg_i    = 1'b0;
    ex_wd_i      = 5'd0;
    ex_wdata_i   = 32'h0;
    ex_is_load_i = 1'b0;
    mem_wreg_i   = 1'b0;
    mem_wd_i     = 5'd0;
    mem_wdata_i  = 32'h0;
  endtask

  initial begin
    rst        = 1'b0;
    pc_i       = 32'h0;
    inst_i     = 32'h0;
    stall_i    = 5'b0;
    flush_i    = 5'b0;
    rs1_data_i = 32'h0;
    rs2_data_i = 32'h0;
    clear_fwd();

    // Reset: outputs zero, stall_o suppressed even with a load-use pattern.
    inst_i       = 32'h00020333;            // ADD x6,x4,x0
    ex_is_load_i = 1'b1;
    ex_wreg_i    = 1'b1;
    ex_wd_i      = 5'd4;
    #1;
    chk("rst_stall_o", 32'(stall_o), 32'h0);
    tick();
    chk("rst_pc_o",   pc_o, 32'h0);
    chk("rst_wreg_o", 32'(wreg_o), 32'h0);
    chk("rst_op_o",   32'(op_o), 32'h0);
    chk("rst_imm_o",  imm_o, 32'h0);
    rst = 1'b1;
    clear_fwd();

    // ADDI x5,x0,-1; rs2 field (31) is unused so a load to x31 must not stall.
    pc_i         = 32'h100;
    inst_i       = 32'hFFF00293;
    rs1_data_i   = 32'hDEAD;
    ex_wreg_i    = 1'b1;
    ex_wd_i      = 5'd31;
    ex_is_load_i = 1'b1;
    #1;
    chk("addi_rs1_addr", 32'(rs1_addr_o), 32'd0);
    chk("addi_rs2_addr", 32'(rs2_addr_o), 32'd31);
    chk("addi_no_stall", 32'(stall_o), 32'h0);
    tick();
    chk("addi_imm",     imm_o, 32'hFFFFFFFF);
    chk("addi_rd",      32'(rd_o), 32'd5);
    chk("addi_wreg",    32'(wreg_o), 32'd1);
    chk("addi_op",      32'(op_o), 32'd1);
    chk("addi_pc",      pc_o, 32'h100);
    chk("addi_opcode",  32'(opcode_o), 32'h13);
    chk("addi_rs1_val", rs1_val_o, 32'h0);
    clear_fwd();

    // ADD x3,x1,x2 with rs1 from EX and rs2 from MEM.
    pc_i        = 32'h104;
    inst_i      = 32'h002081B3;
    rs1_data_i  = 32'h11;
    rs2_data_i  = 32'h22;
    ex_wreg_i   = 1'b1;
    ex_wd_i     = 5'd1;
    ex_wdata_i  = 32'd7;
    mem_wreg_i  = 1'b1;
    mem_wd_i    = 5'd2;
    mem_wdata_i = 32'd9;
    tick();
    chk("add_rs1_ex",  rs1_val_o, 32'd7);
    chk("add_rs2_mem", rs2_val_o, 32'd9);
    chk("add_rd",      32'(rd_o), 32'd3);
    chk("add_imm",     imm_o, 32'h0);

    // SUB x3,x1,x2: EX and MEM both target x2, EX wins; x1 from regfile.
    inst_i      = 32'h402081B3;
    ex_wd_i     = 5'd2;
    ex_wdata_i  = 32'hAA;
    mem_wdata_i = 32'hBB;
    tick();
    chk("sub_rs1_rf",   rs1_val_o, 32'h11);
    chk("sub_rs2_exp",  rs2_val_o, 32'hAA);
    chk("sub_funct7b5", 32'(funct7b5_o), 32'd1);
    clear_fwd();

    // Load-use: LW x4 in EX, ADD x6,x4,x0 in ID -> stall, then bubble.
    pc_i         = 32'h108;
    inst_i       = 32'h00020333;
    ex_is_load_i = 1'b1;
    ex_wreg_i    = 1'b1;
    ex_wd_i      = 5'd4;
    #1;
    chk("lu_stall_o", 32'(stall_o), 32'd1);
    stall_i = 5'b00111;
    tick();
    chk("lu_bub_pc",   pc_o, 32'h108);
    chk("lu_bub_wreg", 32'(wreg_o), 32'd0);
    chk("lu_bub_op",   32'(op_o), 32'd0);
    chk("lu_bub_rd",   32'(rd_o), 32'd0);
    chk("lu_bub_opc",  32'(opcode_o), 32'd0);
    stall_i = 5'b0;
    clear_fwd();

    // BEQ x0,x0,-8
    pc_i   = 32'h10C;
    inst_i = 32'hFE000CE3;
    tick();
    chk("beq_imm",  imm_o, 32'hFFFFFFF8);
    chk("beq_op",   32'(op_o), 32'd3);
    chk("beq_wreg", 32'(wreg_o), 32'd0);

    // JAL x0,+8 and JAL x1,+8
    inst_i = 32'h0080006F;
    tick();
    chk("jal0_imm",  imm_o, 32'd8);
    chk("jal0_wreg", 32'(wreg_o), 32'd0);
    chk("jal0_op",   32'(op_o), 32'd3);
    inst_i = 32'h008000EF;
    tick();
    chk("jal1_wreg", 32'(wreg_o), 32'd1);

    // LW x7,-4(x2), operand from the regfile
    inst_i     = 32'hFFC12383;
    rs1_data_i = 32'h1234;
    tick();
    chk("lw_imm",    imm_o, 32'hFFFFFFFC);
    chk("lw_op",     32'(op_o), 32'd2);
    chk("lw_funct3", 32'(funct3_o), 32'd2);
    chk("lw_rs1",    rs1_val_o, 32'h1234);
    chk("lw_wreg",   32'(wreg_o), 32'd1);

    // SW x5,12(x1), rs2 from MEM
    inst_i      = 32'h0050A623;
    mem_wreg_i  = 1'b1;
    mem_wd_i    = 5'd5;
    mem_wdata_i = 32'h55;
    tick();
    chk("sw_imm",  imm_o, 32'd12);
    chk("sw_op",   32'(op_o), 32'd2);
    chk("sw_wreg", 32'(wreg_o), 32'd0);
    chk("sw_rs2",  rs2_val_o, 32'h55);
    clear_fwd();

    // LUI x10,0x12345 at pc 0x120
    pc_i   = 32'h120;
    inst_i = 32'h12345537;
    tick();
    chk("lui_imm",  imm_o, 32'h12345000);
    chk("lui_wreg", 32'(wreg_o), 32'd1);
    chk("lui_op",   32'(op_o), 32'd1);

    // Hold for 3 cycles while the inputs change.
    stall_i = 5'b01111;
    pc_i    = 32'h300;
    inst_i  = 32'hFFF00293;
    tick();
    tick();
    tick();
    chk("hold_imm", imm_o, 32'h12345000);
    chk("hold_pc",  pc_o, 32'h120);
    chk("hold_rd",  32'(rd_o), 32'd10);

    // Flush during hold -> bubble carrying the current PC.
    flush_i = 5'b00100;
    tick();
    chk("flush_hold_pc",  pc_o, 32'h300);
    chk("flush_hold_op",  32'(op_o), 32'd0);
    chk("flush_hold_imm", imm_o, 32'h0);

    // Flush overrides a normal capture.
    stall_i = 5'b0;
    pc_i    = 32'h304;
    tick();
    chk("flush_cap_pc",   pc_o, 32'h304);
    chk("flush_cap_wreg", 32'(wreg_o), 32'd0);
    flush_i = 5'b0;

    // x0 is never forwarded; a load to x0 in EX never stalls.
    inst_i       = 32'h00000333;            // ADD x6,x0,x0
    rs1_data_i   = 32'h77;
    rs2_data_i   = 32'h88;
    ex_wreg_i    = 1'b1;
    ex_wd_i      = 5'd0;
    ex_wdata_i   = 32'd5;
    ex_is_load_i = 1'b1;
    #1;
    chk("x0_no_stall", 32'(stall_o), 32'd0);
    ex_is_load_i = 1'b0;
    tick();
    chk("x0_rs1", rs1_val_o, 32'h0);
    chk("x0_rs2", rs2_val_o, 32'h0);
    clear_fwd();

    // Unknown opcode 7'b0001011
    inst_i = 32'h0000008B;
    tick();
    chk("ill_flag", 32'(illegal_o), 32'd1);
    chk("ill_wreg", 32'(wreg_o), 32'd0);
    chk("ill_op",   32'(op_o), 32'd0);

    // Explicit bubble instruction clears illegal_o.
    inst_i = 32'h0;
    pc_i   = 32'h308;
    tick();
    chk("bub_illegal", 32'(illegal_o), 32'd0);
    chk("bub_pc",      pc_o, 32'h308);

    // Asynchronous reset mid-stream, then resume on the next edge.
    inst_i = 32'hFFF00293;
    pc_i   = 32'h30C;
    tick();
    chk("pre_rst_wreg", 32'(wreg_o), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_pc",   pc_o, 32'h0);
    chk("arst_imm",  imm_o, 32'h0);
    chk("arst_wreg", 32'(wreg_o), 32'd0);
    chk("arst_rd",   32'(rd_o), 32'd0);
    pc_i = 32'h200;
    #2;
    rst = 1'b1;
    tick();
    chk("resume_pc",   pc_o, 32'h200);
    chk("resume_wreg", 32'(wreg_o), 32'd1);
    chk("resume_imm",  imm_o, 32'hFFFFFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
